decode_queue: RTL and testbench

Parametrised instruction-decode stage for the PIC16F84-compatible core, sitting between program-memory fetch and execute. Each accepted 14-bit instruction word is decoded into an opcode index, a zero-extended operand field, a register-file select code and an illegal flag. The result is pushed into a DEPTH-entry queue drained by execute under a valid/ready handshake. Compared with the previous decode stage, it adds back-pressure, buffering, flush, new opcodes (NOP/CLRWDT/SLEEP), explicit illegal reporting and a saturating illegal counter.

---
 rtl/decode_pkg.sv | 118 +++++++++++
 rtl/decode_queue_if.sv | 25 ++
 rtl/decode_fifo.sv | 60 ++++++
 rtl/decode_queue.sv | 61 ++++++
 tb/tb_decode_queue.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types, opcode indices and the combinational instruction decoder
// for the PIC16F84-compatible decode queue.
package decode_pkg;

    localparam int OP_BITS  = 6;
    localparam int OPD_BITS = 10;

    localparam logic [OP_BITS-1:0] OP_NOP     = 6'd0;
    localparam logic [OP_BITS-1:0] OP_CALL    = 6'd1;
    localparam logic [OP_BITS-1:0] OP_GOTO    = 6'd2;
    localparam logic [OP_BITS-1:0] OP_BCF     = 6'd3;
    localparam logic [OP_BITS-1:0] OP_BSF     = 6'd4;
    localparam logic [OP_BITS-1:0] OP_BTFSC   = 6'd5;
    localparam logic [OP_BITS-1:0] OP_BTFSS   = 6'd6;
    localparam logic [OP_BITS-1:0] OP_MOVLW   = 6'd7;
    localparam logic [OP_BITS-1:0] OP_RETLW   = 6'd8;
    localparam logic [OP_BITS-1:0] OP_SUBLW   = 6'd9;
    localparam logic [OP_BITS-1:0] OP_ADDLW   = 6'd10;
    localparam logic [OP_BITS-1:0] OP_SUBWF   = 6'd11;
    localparam logic [OP_BITS-1:0] OP_DECF    = 6'd12;
    localparam logic [OP_BITS-1:0] OP_IORWF   = 6'd13;
    localparam logic [OP_BITS-1:0] OP_ANDWF   = 6'd14;
    localparam logic [OP_BITS-1:0] OP_XORWF   = 6'd15;
    localparam logic [OP_BITS-1:0] OP_ADDWF   = 6'd16;
    localparam logic [OP_BITS-1:0] OP_MOVF    = 6'd17;
    localparam logic [OP_BITS-1:0] OP_COMF    = 6'd18;
    localparam logic [OP_BITS-1:0] OP_INCF    = 6'd19;
    localparam logic [OP_BITS-1:0] OP_DECFSZ  = 6'd20;
    localparam logic [OP_BITS-1:0] OP_RRF     = 6'd21;
    localparam logic [OP_BITS-1:0] OP_RLF     = 6'd22;
    localparam logic [OP_BITS-1:0] OP_SWAPF   = 6'd23;
    localparam logic [OP_BITS-1:0] OP_INCFSZ  = 6'd24;
    localparam logic [OP_BITS-1:0] OP_IORLW   = 6'd25;
    localparam logic [OP_BITS-1:0] OP_ANDLW   = 6'd26;
    localparam logic [OP_BITS-1:0] OP_XORLW   = 6'd27;
    localparam logic [OP_BITS-1:0] OP_CLRF    = 6'd28;
    localparam logic [OP_BITS-1:0] OP_CLRW    = 6'd29;
    localparam logic [OP_BITS-1:0] OP_MOVWF   = 6'd30;
    localparam logic [OP_BITS-1:0] OP_RETURN  = 6'd31;
    localparam logic [OP_BITS-1:0] OP_RETFIE  = 6'd32;
    localparam logic [OP_BITS-1:0] OP_CLRWDT  = 6'd33;
    localparam logic [OP_BITS-1:0] OP_SLEEP   = 6'd34;
    localparam logic [OP_BITS-1:0] OP_ILLEGAL = '1;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_MOVWF = 2'b01,
        SEL_DST   = 2'b10,
        SEL_ILL   = 2'b11
    } sel_t;

    typedef struct packed {
        logic [OP_BITS-1:0]  opcode;
        logic [OPD_BITS-1:0] operand;
        sel_t                sel;
        logic                illegal;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Priority chain: the first matching opcode group wins.
    function automatic entry_t decode_word(input logic [13:0] w);
        entry_t e;
        logic   hit;
        e.opcode  = OP_ILLEGAL;
        e.operand = w[9:0];
        e.sel     = SEL_ILL;
        e.illegal = 1'b1;
        hit       = 1'b1;
        if (w[13:12] == 2'b10) begin
            e.opcode  = w[11] ? OP_GOTO : OP_CALL;
            e.operand = w[9:0];
        end else if (w[13:12] == 2'b01) begin
            e.opcode  = OP_BCF + {4'b0000, w[11:10]};
            e.operand = w[9:0];
        end else if (w[13:10] == 4'b1100 || w[13:10] == 4'b1101) begin
            e.opcode  = w[10] ? OP_RETLW : OP_MOVLW;
            e.operand = w[9:0];
        end else if (w[13:10] == 4'b1111) begin
            e.opcode  = w[9] ? OP_ADDLW : OP_SUBLW;
            e.operand = {1'b0, w[8:0]};
        end else if (w[13:12] == 2'b00 && w[11:9] != 3'b000) begin
            e.opcode  = {2'b00, w[11:8]} + 6'd9;
            e.operand = {2'b00, w[7:0]};
        end else if (w[13:10] == 4'b1110 && w[9:8] != 2'b11) begin
            e.opcode  = OP_IORLW + {4'b0000, w[9:8]};
            e.operand = {2'b00, w[7:0]};
        end else if (w[13:9] == 5'b00000 && w[8:7] != 2'b00) begin
            // 11 -> CLRF, 10 -> CLRW, 01 -> MOVWF
            e.opcode  = 6'd31 - {4'b0000, w[8:7]};
            e.operand = {3'b000, w[6:0]};
        end else begin
            e.operand = '0;
            case (w)
                14'h0000: e.opcode = OP_NOP;
                14'h0008: e.opcode = OP_RETURN;
                14'h0009: e.opcode = OP_RETFIE;
                14'h0063: e.opcode = OP_SLEEP;
                14'h0064: e.opcode = OP_CLRWDT;
                default: begin
                    hit       = 1'b0;
                    e.operand = w[9:0];
                end
            endcase
        end
        if (hit) begin
            e.illegal = 1'b0;
            if (e.opcode == OP_MOVWF)
                e.sel = SEL_MOVWF;
            else if (w[7] && e.opcode inside {OP_SUBWF, OP_IORWF, OP_ANDWF, OP_XORWF, OP_ADDWF})
                e.sel = SEL_DST;
            else
                e.sel = SEL_NONE;
        end
        return e;
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
interface decode_queue_if #(
    parameter int OPW = 6,
    parameter int ODW = 10
);
    logic           in_valid;
    logic           in_ready;
    logic [13:0]    in_instr;
    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] out_opcode;
    logic [ODW-1:0] out_operand;
    logic [1:0]     out_sel;
    logic           out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_operand, out_sel, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_operand, out_sel, out_illegal
    );
endinterface

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO with occupancy count, synchronous flush and
// asynchronous reset; reads zero while empty.
module decode_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decode_queue.sv
// Instruction decode stage: decodes each accepted word and buffers it for
// execute, counting accepted illegal words.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OPW   = 6,
    parameter int ODW   = 10,
    parameter int CW    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    decode_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [CW-1:0]          illegal_cnt
);
    localparam int CNTW = $clog2(DEPTH) + 1;

    entry_t             in_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] head_bits;
    logic               push;
    logic               pop;

    assign in_entry      = decode_word(bus.in_instr);
    assign bus.in_ready  = (count < CNTW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    decode_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head_bits),
        .count (count)
    );

    assign head = head_bits;

    // Illegal opcode stays all-ones even when OPW is wider than the stored index.
    assign bus.out_opcode  = head.illegal ? {OPW{1'b1}} : OPW'(head.opcode);
    assign bus.out_operand = ODW'(head.operand);
    assign bus.out_sel     = head.sel;
    assign bus.out_illegal = head.illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            illegal_cnt <= '0;
        else if (push && !flush && in_entry.illegal && illegal_cnt != '1)
            illegal_cnt <= illegal_cnt + 1'b1;
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table, hand-written
// corner sequences and a randomized run against a rule-table queue model.
module tb_decode_queue;

    localparam int DEPTH = 2;
    localparam int OPW   = 6;
    localparam int ODW   = 10;
    localparam int CW    = 2;

    typedef struct packed {
        logic [5:0] op;
        logic [9:0] opd;
        logic [1:0] sel;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [13:0] mask;
        logic [13:0] val;
        int          op;
        int          ow;
    } rule_t;

    typedef struct {
        logic [13:0] instr;
        exp_t        e;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic [1:0]      count;
    logic [CW-1:0]   illegal_cnt;

    rule_t rules[$];
    vec_t  vecs[$];
    exp_t  mq[$];
    int    m_ill;
    int    tests = 0;
    int    fails = 0;

    decode_queue_if #(.OPW(OPW), .ODW(ODW)) bus ();

    decode_queue #(
        .DEPTH (DEPTH),
        .OPW   (OPW),
        .ODW   (ODW),
        .CW    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus),
        .count       (count),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clock = ~clock;

    task automatic add_rule(input logic [13:0] m, input logic [13:0] v, input int op, input int ow);
        rule_t r;
        r.mask = m;
        r.val  = v;
        r.op   = op;
        r.ow   = ow;
        rules.push_back(r);
    endtask

    task automatic add_vec(input logic [13:0] w, input int op, input int opd, input int sel, input bit ill);
        vec_t v;
        v.instr = w;
        v.e.op  = 6'(op);
        v.e.opd = 10'(opd);
        v.e.sel = 2'(sel);
        v.e.ill = ill;
        vecs.push_back(v);
    endtask

    // Reference decoder: one mask/value rule per mnemonic, first match wins.
    function automatic exp_t model_decode(input logic [13:0] w);
        exp_t e;
        e.op  = 6'd63;
        e.opd = w[9:0];
        e.sel = 2'd3;
        e.ill = 1'b1;
        foreach (rules[i]) begin
            if ((w & rules[i].mask) == rules[i].val) begin
                e.op  = 6'(rules[i].op);
                e.opd = 10'(w & ((14'd1 << rules[i].ow) - 14'd1));
                e.ill = 1'b0;
                if (rules[i].op == 30)
                    e.sel = 2'd1;
                else if (w[7] && (rules[i].op == 11 || rules[i].op == 13 || rules[i].op == 14 ||
                                  rules[i].op == 15 || rules[i].op == 16))
                    e.sel = 2'd2;
                else
                    e.sel = 2'd0;
                return e;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        exp_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid",   32'(bus.out_valid),   32'(mq.size() > 0));
        chk("in_ready",    32'(bus.in_ready),    32'(mq.size() < DEPTH));
        chk("count",       32'(count),           32'(mq.size()));
        chk("illegal_cnt", 32'(illegal_cnt),     32'(m_ill));
        chk("out_opcode",  32'(bus.out_opcode),  32'(h.op));
        chk("out_operand", 32'(bus.out_operand), 32'(h.opd));
        chk("out_sel",     32'(bus.out_sel),     32'(h.sel));
        chk("out_illegal", 32'(bus.out_illegal), 32'(h.ill));
    endtask

    task automatic model_step(input logic v, input logic [13:0] w, input logic r, input logic f);
        int   sz;
        bit   psh;
        bit   pp;
        exp_t e;
        sz  = mq.size();
        psh = v && (sz < DEPTH);
        pp  = r && (sz > 0);
        e   = model_decode(w);
        if (f) begin
            mq.delete();
        end else begin
            if (pp)
                mq.delete(0);
            if (psh) begin
                mq.push_back(e);
                if (e.ill && m_ill < (1 << CW) - 1)
                    m_ill++;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [13:0] w, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.out_ready = r;
        flush         = f;
        @(posedge clock);
        model_step(v, w, r, f);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst_count",       32'(count),           32'd0);
        chk("rst_illegal_cnt", 32'(illegal_cnt),     32'd0);
        chk("rst_out_opcode",  32'(bus.out_opcode),  32'd0);
        chk("rst_out_operand", 32'(bus.out_operand), 32'd0);
        chk("rst_out_sel",     32'(bus.out_sel),     32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        mq.delete();
        m_ill = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic chk_head(input string name, input int op, input int opd, input int sel);
        chk({name, "_op"},  32'(bus.out_opcode),  32'(op));
        chk({name, "_opd"}, 32'(bus.out_operand), 32'(opd));
        chk({name, "_sel"}, 32'(bus.out_sel),     32'(sel));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        m_ill         = 0;

        add_rule(14'h3800, 14'h2000, 1, 10);
        add_rule(14'h3800, 14'h2800, 2, 10);
        add_rule(14'h3C00, 14'h1000, 3, 10);
        add_rule(14'h3C00, 14'h1400, 4, 10);
        add_rule(14'h3C00, 14'h1800, 5, 10);
        add_rule(14'h3C00, 14'h1C00, 6, 10);
        add_rule(14'h3C00, 14'h3000, 7, 10);
        add_rule(14'h3C00, 14'h3400, 8, 10);
        add_rule(14'h3E00, 14'h3C00, 9, 9);
        add_rule(14'h3E00, 14'h3E00, 10, 9);
        for (int k = 2; k <= 15; k++)
            add_rule(14'h3F00, 14'(k << 8), 9 + k, 8);
        add_rule(14'h3F00, 14'h3800, 25, 8);
        add_rule(14'h3F00, 14'h3900, 26, 8);
        add_rule(14'h3F00, 14'h3A00, 27, 8);
        add_rule(14'h3F80, 14'h0180, 28, 7);
        add_rule(14'h3F80, 14'h0100, 29, 7);
        add_rule(14'h3F80, 14'h0080, 30, 7);
        add_rule(14'h3FFF, 14'h0008, 31, 0);
        add_rule(14'h3FFF, 14'h0009, 32, 0);
        add_rule(14'h3FFF, 14'h0000, 0, 0);
        add_rule(14'h3FFF, 14'h0064, 33, 0);
        add_rule(14'h3FFF, 14'h0063, 34, 0);

        add_vec(14'h2805, 2,  10'h005, 0, 0);
        add_vec(14'h2123, 1,  10'h123, 0, 0);
        add_vec(14'h1680, 4,  10'h280, 0, 0);
        add_vec(14'h1C81, 6,  10'h081, 0, 0);
        add_vec(14'h3480, 8,  10'h080, 0, 0);
        add_vec(14'h3C15, 9,  10'h015, 0, 0);
        add_vec(14'h3F00, 10, 10'h100, 0, 0);
        add_vec(14'h0215, 11, 10'h015, 0, 0);
        add_vec(14'h0295, 11, 10'h095, 2, 0);
        add_vec(14'h0790, 16, 10'h090, 2, 0);
        add_vec(14'h0A95, 19, 10'h095, 0, 0);
        add_vec(14'h3A7F, 27, 10'h07F, 0, 0);
        add_vec(14'h01A3, 28, 10'h023, 0, 0);
        add_vec(14'h0103, 29, 10'h003, 0, 0);
        add_vec(14'h0085, 30, 10'h005, 1, 0);
        add_vec(14'h0008, 31, 10'h000, 0, 0);
        add_vec(14'h0009, 32, 10'h000, 0, 0);
        add_vec(14'h0000, 0,  10'h000, 0, 0);
        add_vec(14'h0064, 33, 10'h000, 0, 0);
        add_vec(14'h0063, 34, 10'h000, 0, 0);
        add_vec(14'h0001, 63, 10'h001, 3, 1);
        add_vec(14'h0070, 63, 10'h070, 3, 1);
        add_vec(14'h3B00, 63, 10'h300, 3, 1);

        @(posedge clock);
        #1;
        do_reset();

        // Decode table: push into empty queue, inspect head, pop back to empty.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].instr, 1'b0, 1'b0);
            chk("vec_op",  32'(bus.out_opcode),  32'(vecs[i].e.op));
            chk("vec_opd", 32'(bus.out_operand), 32'(vecs[i].e.opd));
            chk("vec_sel", 32'(bus.out_sel),     32'(vecs[i].e.sel));
            chk("vec_ill", 32'(bus.out_illegal), 32'(vecs[i].e.ill));
            cycle(1'b0, 14'h0, 1'b1, 1'b0);
            chk("vec_empty", 32'(bus.out_valid), 32'd0);
        end

        // ADDWF with d=1 followed by MOVWF, heads in order.
        do_reset();
        cycle(1'b1, 14'h0790, 1'b0, 1'b0);
        cycle(1'b1, 14'h0085, 1'b0, 1'b0);
        chk_head("pair0", 16, 10'h090, 2);
        cycle(1'b0, 14'h0, 1'b1, 1'b0);
        chk_head("pair1", 30, 10'h005, 1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0);

        // Full queue: third word held, no bypass while full, order preserved.
        do_reset();
        cycle(1'b1, 14'h2805, 1'b0, 1'b0);
        cycle(1'b1, 14'h3F00, 1'b0, 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 14'h0085, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd2);
        chk_head("full_h0", 2, 10'h005, 0);
        cycle(1'b1, 14'h0085, 1'b1, 1'b0);
        chk("nobypass_count", 32'(count), 32'd1);
        chk_head("full_h1", 10, 10'h100, 0);
        cycle(1'b1, 14'h0085, 1'b1, 1'b0);
        chk("pushpop_count", 32'(count), 32'd1);
        chk_head("full_h2", 30, 10'h005, 1);
        cycle(1'b0, 14'h0, 1'b1, 1'b0);

        // Illegal reporting and saturation at 3 with CW=2.
        do_reset();
        cycle(1'b1, 14'h3F00, 1'b0, 1'b0);
        chk_head("addlw", 10, 10'h100, 0);
        cycle(1'b1, 14'h0064, 1'b1, 1'b0);
        chk_head("clrwdt", 33, 10'h000, 0);
        cycle(1'b1, 14'h0001, 1'b1, 1'b0);
        chk_head("illegal", 63, 10'h001, 3);
        chk("illegal_flag", 32'(bus.out_illegal), 32'd1);
        chk("illegal_cnt1", 32'(illegal_cnt), 32'd1);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 14'(14'h3B00 + i), 1'b1, 1'b0);
        chk("illegal_sat", 32'(illegal_cnt), 32'd3);

        // Flush: drops queued words and a coinciding push, keeps illegal_cnt.
        do_reset();
        cycle(1'b1, 14'h2805, 1'b0, 1'b0);
        cycle(1'b1, 14'h0790, 1'b0, 1'b0);
        cycle(1'b1, 14'h0001, 1'b0, 1'b1);
        chk("flush_full_count", 32'(count), 32'd0);
        cycle(1'b1, 14'h0085, 1'b0, 1'b0);
        cycle(1'b1, 14'h0001, 1'b0, 1'b1);
        chk("flush_push_count", 32'(count), 32'd0);
        chk("flush_push_ill",   32'(illegal_cnt), 32'd0);
        cycle(1'b1, 14'h0001, 1'b0, 1'b0);
        cycle(1'b0, 14'h0, 1'b0, 1'b1);
        chk("flush_keeps_ill", 32'(illegal_cnt), 32'd1);

        // Asynchronous reset in the middle of traffic, then clean restart.
        cycle(1'b1, 14'h2805, 1'b0, 1'b0);
        cycle(1'b1, 14'h0001, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 14'h2805, 1'b0, 1'b0);
        chk_head("after_rst", 2, 10'h005, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [13:0] w;
            if ($urandom_range(0, 1) == 0)
                w = 14'($urandom);
            else
                w = vecs[$urandom_range(0, vecs.size() - 1)].instr;
            cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
            chk("count_bound", 32'(count <= 2'd2), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
